spi_cmd_rx: RTL and testbench

Clock-domain SPI command receiver that sits directly upstream of the LED matrix multiplexer core. It oversamples the raw `sck`/`sdi`/`cs` pins in the `clk` domain and assembles MSB-first frames. On a correctly sized frame it updates a held command byte `val`, which drives the sun/moon/static pattern selection downstream. Malformed frames are flagged and discarded, so the display never sees a partial byte.

---
 rtl/spi_cmd_rx_if.sv | 30 +++
 rtl/spi_cmd_rx.sv | 163 ++++++++++++++++
 tb/tb_spi_cmd_rx.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_rx_if.sv
// spi_cmd_rx_if
// Groups the SPI pins and command outputs of spi_cmd_rx so they travel as one port.
//   sck, sdi, cs : raw SPI pins. The master drives them and the receiver samples them.
//   val          : last accepted command (DATA_W bits).
//   val_valid    : one-cycle pulse when val updates.
//   frame_err    : one-cycle pulse when a frame with a bad bit count closes.
//   busy         : high while a frame is being received.
//   frame_cnt    : count of good frames. It wraps from 255 to 0.
interface spi_cmd_rx_if #(
    parameter int DATA_W = 8
);
    logic              sck;
    logic              sdi;
    logic              cs;
    logic [DATA_W-1:0] val;
    logic              val_valid;
    logic              frame_err;
    logic              busy;
    logic [7:0]        frame_cnt;

    modport master (
        output sck, sdi, cs,
        input  val, val_valid, frame_err, busy, frame_cnt
    );

    modport slave (
        input  sck, sdi, cs,
        output val, val_valid, frame_err, busy, frame_cnt
    );
endinterface

// File: rtl/spi_cmd_rx.sv
// spi_cmd_rx
// This block oversamples the raw SPI pins in the clk domain and assembles MSB-first frames.
// A frame of exactly DATA_W bits updates the held command byte. A frame with any other
// non-zero bit count is flagged and discarded.
//   clk    : system clock
//   reset  : synchronous, active-low reset
//   bus    : spi_cmd_rx_if.slave, which carries the pins sck/sdi/cs and the outputs
//            val/val_valid/frame_err/busy/frame_cnt
//
// state  | meaning
// IDLE   | waiting for cs to rise
// RECV   | frame open, shifting bits on sck rising edges
// COMMIT | frame closed, accept the frame or flag an error based on the bit count
module spi_cmd_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    spi_cmd_rx_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam int ST_W  = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);
    localparam logic [ST_W-1:0]  SETTLE   = ST_W'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_COMMIT
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_sck_sync;
    logic [SYNC_STAGES-1:0]  r_sdi_sync;
    logic [SYNC_STAGES-1:0]  r_cs_sync;
    logic                    r_sck_h;
    logic                    r_cs_h;
    logic [ST_W-1:0]         r_settle;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_W-1:0]       r_shift;
    logic [DATA_W-1:0]       r_val;
    logic                    r_val_valid;
    logic                    r_frame_err;
    logic [7:0]              r_frame_cnt;

    logic w_sck_s, w_sdi_s, w_cs_s;
    logic w_ready;
    logic w_sck_rise, w_cs_rise, w_cs_fall;
    logic w_clear, w_shift_en, w_good, w_err;

    assign w_sck_s = r_sck_sync[SYNC_STAGES-1];
    assign w_sdi_s = r_sdi_sync[SYNC_STAGES-1];
    assign w_cs_s  = r_cs_sync[SYNC_STAGES-1];

    // The chains clear to 0 on reset. Until the chains and the history flops hold real
    // pin values, the edge detectors are blanked. This stops a cs that is already high at
    // reset release from being seen as a fresh rising edge.
    assign w_ready    = (r_settle == SETTLE);
    assign w_sck_rise = w_ready &  w_sck_s & ~r_sck_h;
    assign w_cs_rise  = w_ready &  w_cs_s  & ~r_cs_h;
    assign w_cs_fall  = w_ready & ~w_cs_s  &  r_cs_h;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sck_sync <= '0;
            r_sdi_sync <= '0;
            r_cs_sync  <= '0;
            r_sck_h    <= 1'b0;
            r_cs_h     <= 1'b0;
            r_settle   <= '0;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], bus.sck};
            r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], bus.sdi};
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs};
            r_sck_h    <= w_sck_s;
            r_cs_h     <= w_cs_s;
            if (!w_ready) begin
                r_settle <= r_settle + ST_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_shift_en  = 1'b0;
        w_good      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_RECV;
                    w_clear     = 1'b1;
                end
            end
            ST_RECV: begin
                // An sck edge that arrives together with cs_fall sees cs_s low and is dropped.
                if (w_sck_rise && w_cs_s) begin
                    w_shift_en = 1'b1;
                end
                if (w_cs_fall) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
                if (r_cnt == CNT_FULL) begin
                    w_good = 1'b1;
                end else if (r_cnt != '0) begin
                    w_err = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_val       <= '0;
            r_val_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_val_valid <= w_good;
            r_frame_err <= w_err;
            if (w_clear) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (w_shift_en) begin
                r_shift <= {r_shift[DATA_W-2:0], w_sdi_s};
                // The count saturates one past full, so any overlong frame still reads as bad.
                if (r_cnt != CNT_SAT) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (w_good) begin
                r_val       <= r_shift;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign bus.val       = r_val;
    assign bus.val_valid = r_val_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = (r_state == ST_RECV);
    assign bus.frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_spi_cmd_rx.sv
module tb_spi_cmd_rx;
    localparam int DW = 8;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    spi_cmd_rx_if #(.DATA_W(DW)) bus ();

    spi_cmd_rx #(
        .DATA_W      (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Expected outcome of one closed frame, in arrival order.
    typedef struct {
        bit         err;
        logic [7:0] data;
    } exp_t;

    exp_t       expq[$];
    exp_t       e_c;
    logic [7:0] m_val = 8'h00;
    logic [7:0] m_cnt = 8'h00;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bit_out(input logic b, input bit fast);
        bus.sdi = b;
        tick(SS + 1 + (fast ? 0 : int'($urandom_range(0, 2))));
        bus.sck = 1'b1;
        tick(SS + 1 + (fast ? 0 : int'($urandom_range(0, 2))));
        bus.sck = 1'b0;
    endtask

    // Sends one frame of nbits, MSB first, and records the outcome the rules require.
    task automatic send(input logic [15:0] data, input int nbits, input int gap, input bit fast);
        bus.cs = 1'b1;
        for (int i = nbits - 1; i >= 0; i--) begin
            bit_out(data[i], fast);
        end
        tick(SS + 3);
        chk("busy_in_frame", 32'(bus.busy), 32'd1);
        if (nbits == DW) expq.push_back('{1'b0, data[7:0]});
        else if (nbits != 0) expq.push_back('{1'b1, 8'h00});
        bus.cs = 1'b0;
        fall_cyc = cyc;
        tick(gap);
    endtask

    task automatic drain();
        tick(SS + 8);
        chk("pending_outcomes", 32'(expq.size()), 32'd0);
        chk("idle_not_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        expq.delete();
        m_val = 8'h00;
        m_cnt = 8'h00;
        tick(3);
        reset = 1'b1;
        tick(1);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (bus.val_valid) begin
                n_valid++;
                if (expq.size() == 0 || expq[0].err) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got val_valid=1 val=%0h want no pulse (cycle %0d)", bus.val, cyc);
                end else begin
                    e_c = expq.pop_front();
                    m_val = e_c.data;
                    m_cnt = m_cnt + 8'd1;
                    chk("val_on_pulse", 32'(bus.val), 32'(m_val));
                    chk("cnt_on_pulse", 32'(bus.frame_cnt), 32'(m_cnt));
                    lat = cyc - fall_cyc;
                    chk("valid_latency_ok", 32'(lat >= SS + 2 && lat <= SS + 3), 32'd1);
                end
            end else begin
                chk("val_stable", 32'(bus.val), 32'(m_val));
                chk("cnt_stable", 32'(bus.frame_cnt), 32'(m_cnt));
            end
            if (bus.frame_err) begin
                n_err++;
                if (expq.size() == 0 || !expq[0].err) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_err: got frame_err=1 want no error pulse (cycle %0d)", cyc);
                end else begin
                    e_c = expq.pop_front();
                    lat = cyc - fall_cyc;
                    chk("err_latency_ok", 32'(lat >= SS + 2 && lat <= SS + 3), 32'd1);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv0, ne0, nb;
        logic [15:0] d;
        bus.sck = 1'b0;
        bus.sdi = 1'b0;
        bus.cs  = 1'b0;
        reset   = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(2);
        chk("rst_val", 32'(bus.val), 32'h0);
        chk("rst_val_valid", 32'(bus.val_valid), 32'h0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'h0);

        // Single clean frame.
        send(16'h00A5, 8, SS + 4, 1'b0);
        drain();
        chk("a5_val", 32'(bus.val), 32'hA5);
        chk("a5_cnt", 32'(bus.frame_cnt), 32'd1);
        chk("a5_nvalid", 32'(n_valid), 32'd1);
        chk("a5_nerr", 32'(n_err), 32'd0);

        // Back-to-back frames at the minimum cs gap.
        do_reset();
        nv0 = n_valid;
        send(16'h0021, 8, SS + 2, 1'b1);
        send(16'h0003, 8, SS + 2, 1'b1);
        drain();
        chk("b2b_val", 32'(bus.val), 32'h03);
        chk("b2b_cnt", 32'(bus.frame_cnt), 32'd2);
        chk("b2b_pulses", 32'(n_valid - nv0), 32'd2);

        // Short and long frames after a good 3C.
        send(16'h003C, 8, SS + 3, 1'b0);
        drain();
        nv0 = n_valid;
        ne0 = n_err;
        send(16'h0015, 5, SS + 2, 1'b0);
        send(16'h02AB, 10, SS + 2, 1'b0);
        drain();
        chk("bad_nerr", 32'(n_err - ne0), 32'd2);
        chk("bad_nvalid", 32'(n_valid - nv0), 32'd0);
        chk("bad_val", 32'(bus.val), 32'h3C);
        chk("bad_cnt", 32'(bus.frame_cnt), 32'd3);

        // cs toggles with no sck edges.
        nv0 = n_valid;
        ne0 = n_err;
        send(16'h0000, 0, SS + 2, 1'b0);
        send(16'h0000, 0, SS + 3, 1'b0);
        drain();
        chk("empty_nvalid", 32'(n_valid - nv0), 32'd0);
        chk("empty_nerr", 32'(n_err - ne0), 32'd0);
        chk("empty_val", 32'(bus.val), 32'h3C);

        // Random mix of frame lengths, data and timing.
        for (int k = 0; k < 24; k++) begin
            d  = 16'($urandom);
            nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : DW;
            send(d, nb, SS + 2 + int'($urandom_range(0, 3)), 1'b0);
        end
        drain();

        // Reset after 4 bits, then release with cs still high and finish the frame.
        nv0 = n_valid;
        ne0 = n_err;
        bus.cs = 1'b1;
        for (int i = 0; i < 4; i++) bit_out(1'b1, 1'b0);
        reset = 1'b0;
        expq.delete();
        m_val = 8'h00;
        m_cnt = 8'h00;
        tick(3);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) bit_out(1'b0, 1'b0);
        tick(3);
        bus.cs = 1'b0;
        fall_cyc = cyc;
        tick(SS + 4);
        drain();
        chk("midrst_val", 32'(bus.val), 32'h00);
        chk("midrst_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("midrst_nvalid", 32'(n_valid - nv0), 32'd0);
        chk("midrst_nerr", 32'(n_err - ne0), 32'd0);
        send(16'h00FF, 8, SS + 3, 1'b0);
        drain();
        chk("ff_val", 32'(bus.val), 32'hFF);

        // 256 good frames wrap the frame counter.
        do_reset();
        nv0 = n_valid;
        d = 16'h0000;
        for (int k = 0; k < 256; k++) begin
            d = 16'($urandom);
            send(d, 8, SS + 2, 1'b1);
        end
        drain();
        chk("wrap_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("wrap_pulses", 32'(n_valid - nv0), 32'd256);
        chk("wrap_last_val", 32'(bus.val), 32'(d[7:0]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
